// File: rtl/tdm_voice_scheduler_pkg.sv
// tdm_voice_scheduler_pkg: shared waveform codes, FSM encoding and default sizes
package tdm_voice_scheduler_pkg;
  localparam int VOICES_DEF      = 8;
  localparam int VOICES_BITS_DEF = 3;
  localparam int PHASE_W_DEF     = 24;
  localparam int ADDR_W_DEF      = 8;
  typedef enum logic [1:0] {
    WAVE_SIN = 2'd0,
    WAVE_TRI = 2'd1,
    WAVE_SQR = 2'd2,
    WAVE_SAW = 2'd3
  } wave_e;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/tdm_voice_scheduler_nco_phase_bank.sv
// tdm_voice_scheduler_nco_phase_bank: per-voice phase accumulators with config regfile
module tdm_voice_scheduler_nco_phase_bank
  import tdm_voice_scheduler_pkg::*;
#(
  parameter int VOICES      = VOICES_DEF,
  parameter int VOICES_BITS = VOICES_BITS_DEF,
  parameter int PHASE_W     = PHASE_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_inc,
  input  logic [VOICES_BITS-1:0] i_idx,
  output logic [ADDR_W-1:0]      o_addr,
  output logic [1:0]             o_wave,
  output logic                   o_en,
  input  logic                   i_we,
  input  logic [VOICES_BITS-1:0] i_wr_idx,
  input  logic [PHASE_W-1:0]     i_tuning,
  input  logic [1:0]             i_wave,
  input  logic                   i_en,
  input  logic                   i_clr
);
  logic [PHASE_W-1:0] r_phase  [VOICES];
  logic [PHASE_W-1:0] r_tuning [VOICES];
  logic [1:0]         r_wave   [VOICES];
  logic               r_en     [VOICES];

  assign o_addr = r_phase[i_idx][PHASE_W-1 -: ADDR_W];
  assign o_wave = r_wave[i_idx];
  assign o_en   = r_en[i_idx];

  // config writes land at the edge; a clear wins over the same-edge increment,
  // and the increment always uses the pre-write tuning and enable
  always_ff @(posedge i_clk) begin
    for (int v = 0; v < VOICES; v++) begin
      if (i_rst) begin
        r_phase[v]  <= '0;
        r_tuning[v] <= '0;
        r_wave[v]   <= WAVE_SIN;
        r_en[v]     <= 1'b0;
      end else begin
        if (i_we && i_wr_idx == VOICES_BITS'(v)) begin
          r_tuning[v] <= i_tuning;
          r_wave[v]   <= i_wave;
          r_en[v]     <= i_en;
        end
        if (i_we && i_clr && i_wr_idx == VOICES_BITS'(v))
          r_phase[v] <= '0;
        else if (i_inc && i_idx == VOICES_BITS'(v) && r_en[v])
          r_phase[v] <= r_phase[v] + r_tuning[v];
      end
    end
  end
endmodule

// File: rtl/tdm_voice_scheduler.sv
// tdm_voice_scheduler: round-robin TDM voice walker feeding the wavetable BRAM interface
module tdm_voice_scheduler
  import tdm_voice_scheduler_pkg::*;
#(
  parameter int VOICES      = VOICES_DEF,
  parameter int VOICES_BITS = VOICES_BITS_DEF,
  parameter int PHASE_W     = PHASE_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst,
  input  logic                   sample_tick,
  input  logic                   cfg_we,
  input  logic [VOICES_BITS-1:0] cfg_voice,
  input  logic [PHASE_W-1:0]     cfg_tuning,
  input  logic [1:0]             cfg_wave,
  input  logic                   cfg_en,
  input  logic                   cfg_phase_clr,
  output logic [ADDR_W-1:0]      nco_addr_out,
  output logic [1:0]             wave_sel_out,
  output logic [VOICES_BITS-1:0] channel_num_out,
  output logic                   is_chan_en_out,
  output logic                   slot_valid,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic                   tick_overrun
);
  logic [0:0]             r_state;
  logic [VOICES_BITS-1:0] r_slot;
  logic                   w_run;
  logic                   w_last;
  logic [ADDR_W-1:0]      w_addr;
  logic [1:0]             w_wave;
  logic                   w_en;

  assign w_run  = (r_state == ST_RUN);
  assign w_last = (r_slot == VOICES_BITS'(VOICES - 1));

  tdm_voice_scheduler_nco_phase_bank #(
    .VOICES(VOICES), .VOICES_BITS(VOICES_BITS), .PHASE_W(PHASE_W), .ADDR_W(ADDR_W)
  ) u_bank (
    .i_clk(sys_clk), .i_rst(sys_rst), .i_inc(w_run), .i_idx(r_slot),
    .o_addr(w_addr), .o_wave(w_wave), .o_en(w_en),
    .i_we(cfg_we), .i_wr_idx(cfg_voice), .i_tuning(cfg_tuning),
    .i_wave(cfg_wave), .i_en(cfg_en), .i_clr(cfg_phase_clr)
  );

  // frame FSM: a tick in IDLE starts a walk over every slot, then back to IDLE
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      r_state <= ST_IDLE;
      r_slot  <= '0;
    end else if (!w_run) begin
      r_state <= sample_tick ? ST_RUN : ST_IDLE;
      r_slot  <= '0;
    end else begin
      r_state <= w_last ? ST_IDLE : ST_RUN;
      r_slot  <= w_last ? '0 : r_slot + VOICES_BITS'(1);
    end
  end

  // registered slot outputs, forced to zero outside a frame
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      nco_addr_out    <= '0;
      wave_sel_out    <= '0;
      channel_num_out <= '0;
      is_chan_en_out  <= 1'b0;
      slot_valid      <= 1'b0;
      frame_busy      <= 1'b0;
      frame_done      <= 1'b0;
      tick_overrun    <= 1'b0;
    end else begin
      nco_addr_out    <= (w_run && w_en) ? w_addr : '0;
      wave_sel_out    <= w_run ? w_wave : 2'b00;
      channel_num_out <= w_run ? r_slot : '0;
      is_chan_en_out  <= w_run && w_en;
      slot_valid      <= w_run;
      frame_busy      <= w_run;
      frame_done      <= slot_valid && channel_num_out == VOICES_BITS'(VOICES - 1);
      tick_overrun    <= w_run && sample_tick;
    end
  end
endmodule

// File: doc/tdm_voice_scheduler.md
# tdm_voice_scheduler

Time-division voice scheduler for the wavetable synth path. On each audio sample tick it walks all voices round-robin, one per clock, advances each voice's phase accumulator by its tuning word, and presents the resulting table address, waveform select and channel tag to the TDM wavetable BRAM interface. It also holds the per-voice configuration (tuning, waveform, enable) written by the control side.

## Interface
- VOICES, 8, number of TDM voice slots per frame
- VOICES_BITS, 3, width of voice index; VOICES == 2**VOICES_BITS
- PHASE_W, 24, phase accumulator / tuning word width
- ADDR_W, 8, wavetable address width (top bits of phase)

- sys_clk  in  1  system clock (48 MHz)
- sys_rst  in  1  synchronous, active-high reset
- sample_tick  in  1  one-cycle strobe, starts a frame
- cfg_we  in  1  config write strobe
- cfg_voice  in  VOICES_BITS  voice index being written
- cfg_tuning  in  PHASE_W  phase increment per frame
- cfg_wave  in  2  waveform: 0 SIN, 1 TRI, 2 SQR, 3 SAW
- cfg_en  in  1  voice enable
- cfg_phase_clr  in  1  with cfg_we: zero that voice's phase
- nco_addr_out  out  ADDR_W  table address, phase[PHASE_W-1 -: ADDR_W]
- wave_sel_out  out  2  waveform for this slot
- channel_num_out  out  VOICES_BITS  voice index of this slot
- is_chan_en_out  out  1  slot carries an enabled voice
- slot_valid  out  1  slot outputs valid this cycle
- frame_busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse after last slot
- tick_overrun  out  1  one-cycle pulse: tick arrived while busy

## Operation
- FSM states IDLE, RUN. Reset -> IDLE; all outputs 0; all phase, tuning, wave, enable storage 0.
- IDLE: sample_tick=1 -> RUN, slot counter := 0.
- RUN, slot s each cycle: emit voice s; if enabled, phase[s] <= phase[s] + tuning[s] mod 2^PHASE_W (wrap silently). Emitted address is the pre-increment phase. Disabled voice: slot still emitted, is_chan_en_out=0, nco_addr_out=0, phase held.
- s == VOICES-1 -> IDLE; counter never exceeds VOICES-1.
- sample_tick while in RUN (or in the cycle the last slot issues): ignored, tick_overrun pulses, frame not restarted.
- Config write: stored at the clock edge. If cfg_voice == voice being processed in the same cycle, the slot uses old config; stored tuning/wave/enable take the new values; phase gets the old-tuning increment unless cfg_phase_clr=1, which forces phase to 0 (clear beats increment).
- cfg_phase_clr without cfg_we: no effect.
- Enable 0->1 does not clear phase; software clears explicitly.

## Timing
- Tick sampled at edge T -> slot k outputs registered, valid during cycle T+1+k, k = 0..VOICES-1.
- frame_busy high cycles T+1 .. T+VOICES; frame_done high cycle T+1+VOICES only.
- Earliest accepted next tick: sampled at edge T+VOICES+1 (i.e. in the frame_done cycle).
- All outputs registered; slot outputs are 0 whenever slot_valid=0.
- Downstream BRAM interface adds 2 cycles; this block does not wait on it (no backpressure).
- sys_rst mid-frame: next cycle IDLE, outputs 0, storage cleared, no frame_done.

## Structure
- Shared package: waveform codes WAVE_SIN/TRI/SQR/SAW (2-bit), FSM state encoding, default VOICES/PHASE_W/ADDR_W constants; the BRAM interface's select decode uses the same codes.
- One sub-module: nco_phase_bank — VOICES x PHASE_W phase storage with single read/increment port, clear port, config regfile beside it. Top holds FSM, slot counter, output registers.

## Test plan
- Reset then voice 0 tuning=0x010000 enabled, two ticks -> frame 1 slot 0 addr 0x00, frame 2 slot 0 addr 0x01; disabled slots show en=0, addr 0.
- Tick at edge T -> slot_valid cycles T+1..T+8, channel_num_out 0..7 in order, frame_done only at T+9.
- Tuning=0xFFFFFF, phase from 0: addrs 0x00, 0xFF, 0xFF (phase 0xFFFFFE) -> wrap checked modulo 2^24.
- Second tick at T+4 -> tick_overrun pulse, slot sequence unchanged, no restart; tick at T+9 accepted.
- Write voice 3 tuning=0x020000 with phase_clr in the cycle slot 3 issues -> that slot uses old config; next frame slot 3 addr 0x00, following 0x02.
- sys_rst at T+5 -> T+6 all outputs 0, no frame_done, next frame all addrs 0.
